// File: rtl/sync_fifo_pro.sv
// sync_fifo_pro: single-clock parametrised FIFO with a fill-level count,
// almost-full/almost-empty thresholds and registered overflow/underflow pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads: the head word is
// pre-loaded into the rdata register. Without it, each accepted read returns
// data one cycle after the accepting edge.
module sync_fifo_pro #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = 14,
    parameter int AE_THRESH  = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [DATA_WIDTH-1:0]       wdata,
    input  logic                        rd_en,
    output logic [DATA_WIDTH-1:0]       rdata,
    output logic                        valid,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_LVL = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] AF_LVL    = AF_THRESH[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_LVL    = AE_THRESH[ADDR_W:0];
    localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] ZERO      = '0;

    // Storage; no reset so it can map onto block RAM.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Pointers carry an extra wrap bit above the index.
    logic [ADDR_W:0]       wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]       rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]       count_q, count_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  valid_q, valid_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  af_q, af_d;
    logic                  ae_q, ae_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;

    // wr_acc: word stored this edge. rd_fetch: memory head moves into rdata_q.
    logic                  wr_acc;
    logic                  rd_fetch;
    logic                  pop;

    // Next-state: acceptance, pointer/count arithmetic and flag derivation.
    always_comb begin
        wr_acc   = wr_en && !full_q;
        rd_fetch = 1'b0;
        pop      = 1'b0;
        wr_ptr_d = wr_ptr_q + (wr_acc ? ONE : ZERO);
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = 1'b0;
        full_d   = full_q;
        empty_d  = empty_q;
        ovf_d    = wr_en && full_q;
        udf_d    = 1'b0;
`ifdef SYNC_FIFO_FWFT_EN
        // The output register counts as storage; it refills from memory
        // whenever it is empty or being popped, so the next word follows
        // the popped one without a bubble.
        pop      = rd_en && valid_q;
        rd_fetch = (!valid_q || pop) && (wr_ptr_q != rd_ptr_q);
        rd_ptr_d = rd_ptr_q + (rd_fetch ? ONE : ZERO);
        valid_d  = rd_fetch ? 1'b1 : (pop ? 1'b0 : valid_q);
        count_d  = count_q + (wr_acc ? ONE : ZERO) - (pop ? ONE : ZERO);
        full_d   = (count_d == DEPTH_LVL);
        empty_d  = !valid_d;
        udf_d    = rd_en && !valid_q;
`else
        // A read while empty is rejected regardless of a same-cycle write,
        // and a write while full is rejected regardless of a same-cycle read.
        pop      = rd_en && !empty_q;
        rd_fetch = pop;
        rd_ptr_d = rd_ptr_q + (rd_fetch ? ONE : ZERO);
        valid_d  = rd_fetch;
        count_d  = count_q + (wr_acc ? ONE : ZERO) - (pop ? ONE : ZERO);
        full_d   = (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]) &&
                   (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]);
        empty_d  = (wr_ptr_d == rd_ptr_d);
        udf_d    = rd_en && empty_q;
`endif
        af_d     = (count_d >= AF_LVL);
        ae_d     = (count_d <= AE_LVL);
    end

    // Memory write port.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= wdata;
        end
    end

    // Registered memory read into the output data register; holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (rd_fetch) begin
            rdata_q <= mem[rd_ptr_q[ADDR_W-1:0]];
        end
    end

    // Pointer, occupancy, flag and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign rdata        = rdata_q;
    assign valid        = valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_pro.sv
// Testbench for sync_fifo_pro. Standard build: directed sequences plus random
// traffic against a queue-based reference model. With SYNC_FIFO_FWFT_EN
// defined, a directed first-word-fall-through sequence runs instead.
module tb_sync_fifo_pro;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [DW-1:0] wdata;
    logic          rd_en;
    logic [DW-1:0] rdata;
    logic          valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [4:0]    count;
    logic          overflow;
    logic          underflow;

    int n_tests = 0;
    int n_fail  = 0;
    int n_cyc   = 0;

    // Reference model: FIFO contents and last returned word.
    logic [DW-1:0] q [$];
    logic [DW-1:0] m_rdata;

    sync_fifo_pro #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wdata       (wdata),
        .rd_en       (rd_en),
        .rdata       (rdata),
        .valid       (valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".rdata"},  32'(rdata), 32'h0);
        check_eq({tag, ".valid"},  32'(valid), 32'h0);
        check_eq({tag, ".count"},  32'(count), 32'h0);
        check_eq({tag, ".full"},   32'(full), 32'h0);
        check_eq({tag, ".empty"},  32'(empty), 32'h1);
        check_eq({tag, ".afull"},  32'(almost_full), 32'h0);
        check_eq({tag, ".aempty"}, 32'(almost_empty), 32'h1);
        check_eq({tag, ".ovf"},    32'(overflow), 32'h0);
        check_eq({tag, ".udf"},    32'(underflow), 32'h0);
    endtask

    // One clock of traffic: drive at negedge, predict from the occupancy
    // rules, check everything 1 time unit after the rising edge.
    task automatic do_cycle(input logic w, input logic [DW-1:0] d, input logic r);
        logic m_full, m_empty, wacc, racc;
        int   sz;
        @(negedge clk);
        wr_en = w;
        wdata = d;
        rd_en = r;
        m_full  = (q.size() == DEPTH);
        m_empty = (q.size() == 0);
        wacc = w && !m_full;
        racc = r && !m_empty;
        if (racc) m_rdata = q.pop_front();
        if (wacc) q.push_back(d);
        sz = q.size();
        @(posedge clk);
        #1;
        n_cyc++;
        check_eq("rdata",  32'(rdata), 32'(m_rdata));
        check_eq("valid",  32'(valid), 32'(racc));
        check_eq("count",  32'(count), 32'(sz));
        check_eq("full",   32'(full), 32'(sz == DEPTH));
        check_eq("empty",  32'(empty), 32'(sz == 0));
        check_eq("afull",  32'(almost_full), 32'(sz >= AF));
        check_eq("aempty", 32'(almost_empty), 32'(sz <= AE));
        check_eq("ovf",    32'(overflow), 32'(w && m_full));
        check_eq("udf",    32'(underflow), 32'(r && m_empty));
        $display("[TB] cyc %0d wr=%0d wd=%02h rd=%0d -> rdata=%02h valid=%0d count=%0d",
                 n_cyc, w, d, r, rdata, valid, count);
    endtask

    // Plain clock step for the FWFT sequence; checks are made by the caller.
    task automatic tick(input logic w, input logic [DW-1:0] d, input logic r);
        @(negedge clk);
        wr_en = w;
        wdata = d;
        rd_en = r;
        @(posedge clk);
        #1;
        n_cyc++;
        $display("[TB] cyc %0d wr=%0d wd=%02h rd=%0d -> rdata=%02h valid=%0d count=%0d",
                 n_cyc, w, d, r, rdata, valid, count);
    endtask

    // Assert reset between clock edges and check outputs before any edge.
    task automatic async_reset_check();
        @(negedge clk);
        #2;
        wr_en = 1'b0;
        rd_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        q.delete();
        m_rdata = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wdata   = '0;
        m_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

`ifdef SYNC_FIFO_FWFT_EN
        tick(1'b1, 8'h5A, 1'b0);
        check_eq("fw.count1", 32'(count), 32'd1);
        check_eq("fw.valid0", 32'(valid), 32'h0);
        tick(1'b0, 8'h00, 1'b0);
        check_eq("fw.valid1", 32'(valid), 32'h1);
        check_eq("fw.rdata5A", 32'(rdata), 32'h5A);
        check_eq("fw.empty0", 32'(empty), 32'h0);
        tick(1'b1, 8'h5B, 1'b0);
        check_eq("fw.count2", 32'(count), 32'd2);
        check_eq("fw.hold5A", 32'(rdata), 32'h5A);
        tick(1'b0, 8'h00, 1'b1);
        check_eq("fw.rdata5B", 32'(rdata), 32'h5B);
        check_eq("fw.valid5B", 32'(valid), 32'h1);
        check_eq("fw.count1b", 32'(count), 32'd1);
        tick(1'b0, 8'h00, 1'b1);
        check_eq("fw.validend", 32'(valid), 32'h0);
        check_eq("fw.emptyend", 32'(empty), 32'h1);
        check_eq("fw.count0", 32'(count), 32'd0);
        check_eq("fw.udf0", 32'(underflow), 32'h0);
        tick(1'b0, 8'h00, 1'b1);
        check_eq("fw.udf1", 32'(underflow), 32'h1);
        async_reset_check();
`else
        // Basic ordering and count progression.
        do_cycle(1'b1, 8'hA5, 1'b0);
        do_cycle(1'b1, 8'h3C, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b1);
        do_cycle(1'b0, 8'h00, 1'b1);

        // Asynchronous reset with 5 words stored, then reuse from index 0.
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 8'($urandom), 1'b0);
        async_reset_check();
        do_cycle(1'b1, 8'h11, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b1);

        // Fill past full, then drain past empty.
        do_cycle(1'b1, 8'hFF, 1'b0);
        for (int i = 0; i < 15; i++) do_cycle(1'b1, 8'(i), 1'b0);
        for (int i = 0; i < 2; i++) do_cycle(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 18; i++) do_cycle(1'b0, 8'h00, 1'b1);

        // Simultaneous read/write at mid level, at full and at empty.
        for (int i = 0; i < 8; i++) do_cycle(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 20; i++) do_cycle(1'b1, 8'($urandom), 1'b1);
        while (q.size() < DEPTH) do_cycle(1'b1, 8'($urandom), 1'b0);
        do_cycle(1'b1, 8'($urandom), 1'b1);
        while (q.size() > 0) do_cycle(1'b0, 8'h00, 1'b1);
        do_cycle(1'b1, 8'($urandom), 1'b1);

        // Random traffic in phases biased towards filling or draining.
        for (int ph = 0; ph < 8; ph++) begin
            int pw;
            int pr;
            pw = (ph % 2 == 0) ? 75 : 30;
            pr = (ph % 2 == 0) ? 30 : 75;
            for (int i = 0; i < 50; i++) begin
                do_cycle(1'($urandom_range(0, 99) < pw), 8'($urandom),
                         1'($urandom_range(0, 99) < pr));
            end
        end
`endif
        wr_en = 1'b0;
        rd_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_pro.md
Name: sync_fifo_pro

Overview:
Single-clock parametrised FIFO. It is the next generation of the team's FIFO block, generalised in width and depth. It adds a fill-level count, programmable almost-full/almost-empty thresholds, registered overflow/underflow pulses, and an optional first-word-fall-through (FWFT) read mode. It sits between same-clock producer/consumer stages where the dual-clock FIFO is unnecessary.

Parameters:
DATA_WIDTH, 8, width of wdata/rdata in bits
DEPTH, 16, number of entries; power of 2, >= 4
AF_THRESH, 14, almost_full asserts when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)
ADDR_W (localparam), $clog2(DEPTH), pointer index width

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  write request
wdata  input  DATA_WIDTH  write data
rd_en  input  1  read request (pop acknowledge in FWFT mode)
rdata  output  DATA_WIDTH  read data
valid  output  1  rdata holds a valid popped/head word
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  ADDR_W+1  current number of stored words, 0..DEPTH
overflow  output  1  one-cycle pulse: write attempted while full
underflow  output  1  one-cycle pulse: read attempted while empty

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n). While rst_n=0, all outputs and state clear immediately: wr_ptr=rd_ptr=0, count=0, rdata=0, valid=0, full=0, empty=1, almost_full=0, almost_empty=1, overflow=0, underflow=0. Memory contents are not reset.
- Pointers: ADDR_W+1 bits with an extra wrap bit. full = (ptrs differ only in MSB); empty = (ptrs equal). Index wraps DEPTH-1 -> 0 with no gap.
- Write accept: wr_en && !full. wdata is stored at mem[wr_ptr] on the rising edge and wr_ptr increments.
- Read accept (standard mode): rd_en && !empty. rdata <= mem[rd_ptr] on the edge, so latency is 1 cycle from the accepting edge. valid=1 for exactly that cycle; otherwise valid=0. rdata holds its last value when no read is accepted.
- The flags do not depend on same-cycle requests. A write while full is rejected even if rd_en is also asserted; only the read is performed. A read while empty is rejected even if wr_en is also asserted; only the write is performed.
- Simultaneous accepted read and write: count is unchanged and both pointers advance.
- count, full, empty, almost_full and almost_empty are registered and updated on the same edge as the pointers. All of them reflect post-edge occupancy.
- overflow <= wr_en && full; underflow <= rd_en && empty. Both are registered single-cycle pulses and assert again every cycle the condition holds.
- Reset mid-operation: the FIFO is discarded and all outputs return to their reset values asynchronously. The first accepted write after rst_n rises goes to index 0.

Optional Feature:
SYNC_FIFO_FWFT_EN.
- Defined: FWFT mode. The head word is pre-loaded into the rdata output register. valid=1 whenever that register holds an unread word, and rdata is the head word. The first write to an empty FIFO makes valid=1 one cycle after the write edge.
- In FWFT mode, rd_en && valid pops the head. The next word, if any, appears on the following cycle with no bubble; otherwise valid drops. empty = !valid.
- In FWFT mode, count includes the word held in the output register. underflow <= rd_en && !valid.
- Undefined: standard mode exactly as in Behaviour.

Test Plan:
- Reset: drive rst_n=0 mid-run with count=5 -> all outputs reach reset values without waiting for a clock edge; after release, write 8'h11 then read -> rdata=8'h11.
- Basic order: write 8'hA5 then 8'h3C, then 2 reads -> rdata=A5 then 3C, each with a 1-cycle valid pulse one cycle after the read edge; count goes 1,2,1,0; empty=1 at end.
- Fill/overflow: write 8'hFF,00,01..0E (16 words), then 2 more cycles with wr_en -> full=1 and count=16 after the 16th write; almost_full=1 from count=14; overflow pulses 2 cycles; memory is unchanged.
- Drain/underflow: read 18 times from full -> data FF,00..0E in order; empty=1 after the 16th read; underflow pulses 2 cycles; almost_empty=1 from count=2.
- Simultaneous: at count=8, wr_en=rd_en=1 for 20 cycles (pointers wrap) -> count stays 8 and output order is preserved. At full with both asserted -> read only, count=15, overflow=1. At empty with both asserted -> write only, count=1, underflow=1.
- FWFT (SYNC_FIFO_FWFT_EN): write 8'h5A to an empty FIFO -> valid=1 and rdata=5A one cycle later with no rd_en. Then write 8'h5B and pop each cycle -> 5A, 5B back-to-back with no bubble; valid=0 afterwards.
